// File: rtl/bram_stream_reader_if.sv
// Bus bundle for the BRAM stream reader: command channel, BRAM read port, output stream and status.
// The reader connects through the slave modport; the command issuer/consumer side uses master.
interface bram_stream_reader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_start_addr;
  logic [ADDR_WIDTH:0]   cmd_len;
  logic                  cmd_dir;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic                  bram_writeEn;
  logic [DATA_WIDTH-1:0] bram_dataOut;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  busy;

  modport slave (
    input  cmd_valid, cmd_start_addr, cmd_len, cmd_dir, bram_dataOut, out_ready,
    output cmd_ready, bram_addr, bram_writeEn, out_valid, out_data, out_last, busy
  );

  modport master (
    output cmd_valid, cmd_start_addr, cmd_len, cmd_dir, bram_dataOut, out_ready,
    input  cmd_ready, bram_addr, bram_writeEn, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Sequential BRAM reader: one read per cycle, absorbs the 1-cycle read latency and
// presents words on a valid/ready stream through a 2-entry skid buffer.
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  bram_stream_reader_if.slave  bus
);
  localparam logic [ADDR_WIDTH-1:0] A_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   R_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  dir_q, dir_d;
  logic                  infl_q, infl_last_q;
  logic [DATA_WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
  logic                  l0_q, l0_d, l1_q, l1_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  pop, push, issue;
  logic [2:0]            occ;

  assign bus.out_valid    = (cnt_q != 2'd0);
  assign bus.out_data     = d0_q;
  assign bus.out_last     = l0_q & bus.out_valid;
  assign bus.bram_addr    = addr_q;
  assign bus.bram_writeEn = 1'b0;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.cmd_ready    = (state_q == S_IDLE);

  assign pop  = bus.out_valid & bus.out_ready;
  assign push = infl_q;
  // Credits: buffered words plus the word still in the BRAM pipe, less what leaves now.
  assign occ  = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          addr_d = bus.cmd_start_addr;
          rem_d  = bus.cmd_len;
          dir_d  = bus.cmd_dir;
          if (bus.cmd_len != '0) state_d = S_READ;
        end
      end
      S_READ: begin
        if (rem_q != '0 && occ < 3'd2) begin
          issue  = 1'b1;
          rem_d  = rem_q - R_ONE;
          addr_d = dir_q ? addr_q - A_ONE : addr_q + A_ONE;
          if (rem_q == R_ONE) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && bus.out_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Head entry always drives the stream; entry 1 only fills when the head is occupied.
  always_comb begin
    d0_d  = d0_q;
    l0_d  = l0_q;
    d1_d  = d1_q;
    l1_d  = l1_q;
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b01: begin
        d0_d  = d1_q;
        l0_d  = l1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b10: begin
        if (cnt_q == 2'd0) begin
          d0_d = bus.bram_dataOut;
          l0_d = infl_last_q;
        end else begin
          d1_d = bus.bram_dataOut;
          l1_d = infl_last_q;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          d0_d = bus.bram_dataOut;
          l0_d = infl_last_q;
        end else begin
          d0_d = d1_q;
          l0_d = l1_q;
          d1_d = bus.bram_dataOut;
          l1_d = infl_last_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      dir_q       <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      d0_q        <= '0;
      l0_q        <= 1'b0;
      d1_q        <= '0;
      l1_q        <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      dir_q       <= dir_d;
      infl_q      <= issue;
      infl_last_q <= issue && (rem_q == R_ONE);
      d0_q        <= d0_d;
      l0_q        <= l0_d;
      d1_q        <= d1_d;
      l1_q        <= l1_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader against a registered read-first BRAM model
// preloaded with mem[i] = 0x100 + i.
module tb_bram_stream_reader;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  bram_stream_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

  bram_stream_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  logic [15:0] mem [0:255];
  always @(posedge clk) bus.bram_dataOut <= mem[bus.bram_addr];

  int n_cmp = 0;
  int n_mis = 0;
  logic [15:0] gd [$];
  bit          gl [$];
  int          gc [$];
  int          stall_viol;
  bit          timed_out;
  int          ovf_cnt = 0;
  int          wen_cnt = 0;
  bit          bp_pat [0:7];

  // Skid buffer must never receive a word while full and not draining.
  always @(posedge clk) begin
    if (rstn && dut.infl_q && dut.cnt_q == 2'd2 && !(bus.out_valid && bus.out_ready)) ovf_cnt++;
    if (bus.bram_writeEn !== 1'b0) wen_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] start, input logic [8:0] len, input logic dir);
    bus.cmd_start_addr = start;
    bus.cmd_len        = len;
    bus.cmd_dir        = dir;
    bus.cmd_valid      = 1'b1;
    tick();
    bus.cmd_valid      = 1'b0;
  endtask

  // Records every handshaked word and the cycle (0 = first cycle after accept) it left.
  task automatic collect(input int budget, input bit bp);
    logic [15:0] hd;
    bit hl;
    bit holding;
    gd.delete(); gl.delete(); gc.delete();
    stall_viol = 0;
    timed_out  = 1'b1;
    holding    = 1'b0;
    hd = '0;
    hl = 1'b0;
    for (int k = 0; k < budget; k++) begin
      bus.out_ready = bp ? bp_pat[k % 8] : 1'b1;
      if (holding && (!bus.out_valid || bus.out_data !== hd || bus.out_last !== hl)) stall_viol++;
      holding = 1'b0;
      if (bus.out_valid && !bus.out_ready) begin
        holding = 1'b1;
        hd = bus.out_data;
        hl = bus.out_last;
      end
      if (bus.out_valid && bus.out_ready) begin
        gd.push_back(bus.out_data);
        gl.push_back(bus.out_last);
        gc.push_back(k);
      end
      tick();
      if (gl.size() > 0 && gl[gl.size()-1]) begin
        timed_out = 1'b0;
        break;
      end
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(); tick();
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_mis++; $display("FAIL reset_cmd_ready got %b want 1", bus.cmd_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_last !== 1'b0) begin n_mis++; $display("FAIL reset_out_last got %b want 0", bus.out_last); end
    n_cmp++; if (bus.out_data !== 16'h0) begin n_mis++; $display("FAIL reset_out_data got %h want 0000", bus.out_data); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.bram_addr !== 8'h00) begin n_mis++; $display("FAIL reset_bram_addr got %h want 00", bus.bram_addr); end
    n_cmp++; if (bus.bram_writeEn !== 1'b0) begin n_mis++; $display("FAIL reset_writeEn got %b want 0", bus.bram_writeEn); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_ascending();
    logic [15:0] exp_d [4] = '{16'h110, 16'h111, 16'h112, 16'h113};
    send_cmd(8'h10, 9'd4, 1'b0);
    n_cmp++; if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin n_mis++; $display("FAIL asc_busy got busy=%b rdy=%b want 1/0", bus.busy, bus.cmd_ready); end
    n_cmp++; if (bus.bram_addr !== 8'h10) begin n_mis++; $display("FAIL asc_first_addr got %h want 10", bus.bram_addr); end
    collect(30, 1'b0);
    n_cmp++; if (timed_out || gd.size() != 4) begin n_mis++; $display("FAIL asc_count got %0d words (timeout=%0d) want 4", gd.size(), timed_out); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (gd[i] !== exp_d[i] || gl[i] !== (i == 3) || gc[i] != i + 2) begin
          n_mis++;
          $display("FAIL asc_word%0d got %h last=%b cyc=%0d want %h last=%b cyc=%0d", i, gd[i], gl[i], gc[i], exp_d[i], i == 3, i + 2);
        end
      end
    end
    n_cmp++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin n_mis++; $display("FAIL asc_idle_after got rdy=%b busy=%b want 1/0", bus.cmd_ready, bus.busy); end
  endtask

  task automatic test_desc_wrap();
    logic [15:0] exp_d [4] = '{16'h101, 16'h100, 16'h1FF, 16'h1FE};
    send_cmd(8'h01, 9'd4, 1'b1);
    collect(30, 1'b0);
    n_cmp++; if (timed_out || gd.size() != 4) begin n_mis++; $display("FAIL desc_count got %0d words (timeout=%0d) want 4", gd.size(), timed_out); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (gd[i] !== exp_d[i] || gl[i] !== (i == 3)) begin
          n_mis++;
          $display("FAIL desc_word%0d got %h last=%b want %h last=%b", i, gd[i], gl[i], exp_d[i], i == 3);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int bad;
    send_cmd(8'h20, 9'd8, 1'b0);
    collect(100, 1'b1);
    n_cmp++; if (timed_out || gd.size() != 8) begin n_mis++; $display("FAIL bp_count got %0d words (timeout=%0d) want 8", gd.size(), timed_out); end
    else begin
      bad = 0;
      for (int i = 0; i < 8; i++) if (gd[i] !== 16'h120 + 16'(i) || gl[i] !== (i == 7)) bad++;
      n_cmp++; if (bad != 0) begin n_mis++; $display("FAIL bp_order got %0d bad words want 0", bad); end
    end
    n_cmp++; if (stall_viol != 0) begin n_mis++; $display("FAIL bp_stable got %0d changes while stalled want 0", stall_viol); end
    n_cmp++; if (ovf_cnt != 0) begin n_mis++; $display("FAIL bp_overflow got %0d overflows want 0", ovf_cnt); end
    n_cmp++; if (wen_cnt != 0) begin n_mis++; $display("FAIL bp_writeEn got %0d write cycles want 0", wen_cnt); end
  endtask

  task automatic test_len_zero();
    int seen;
    send_cmd(8'h12, 9'd0, 1'b0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.cmd_ready !== 1'b1) seen++;
      tick();
    end
    n_cmp++; if (seen != 0) begin n_mis++; $display("FAIL len0_idle got %0d non-idle cycles want 0", seen); end
    send_cmd(8'h55, 9'd1, 1'b0);
    collect(20, 1'b0);
    n_cmp++; if (timed_out || gd.size() != 1 || gd[0] !== 16'h155 || gl[0] !== 1'b1 || gc[0] != 2) begin
      n_mis++;
      $display("FAIL len1_word got %0d words first=%h want 1 word 0155 last=1 cyc=2", gd.size(), gd.size() > 0 ? gd[0] : 16'hxxxx);
    end
  endtask

  task automatic test_full_sweep();
    int bad_d, bad_l;
    send_cmd(8'h80, 9'd256, 1'b0);
    collect(400, 1'b0);
    n_cmp++; if (timed_out || gd.size() != 256) begin n_mis++; $display("FAIL sweep_count got %0d words (timeout=%0d) want 256", gd.size(), timed_out); end
    else begin
      bad_d = 0; bad_l = 0;
      for (int i = 0; i < 256; i++) begin
        if (gd[i] !== 16'h100 + 16'((i + 128) % 256)) bad_d++;
        if (gl[i] !== (i == 255)) bad_l++;
      end
      n_cmp++; if (bad_d != 0) begin n_mis++; $display("FAIL sweep_data got %0d bad words want 0", bad_d); end
      n_cmp++; if (bad_l != 0) begin n_mis++; $display("FAIL sweep_last got %0d bad last flags want 0", bad_l); end
      n_cmp++; if (gc[0] != 2 || gc[255] != 257) begin n_mis++; $display("FAIL sweep_rate got cyc %0d..%0d want 2..257", gc[0], gc[255]); end
    end
  endtask

  task automatic test_mid_reset();
    int got, seen;
    send_cmd(8'h30, 9'd10, 1'b0);
    bus.out_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 40 && got < 3; k++) begin
      if (bus.out_valid) got++;
      tick();
    end
    n_cmp++; if (got != 3) begin n_mis++; $display("FAIL mid_pre got %0d words want 3", got); end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_mis++; $display("FAIL mid_reset got valid=%b busy=%b rdy=%b want 0/0/1", bus.out_valid, bus.busy, bus.cmd_ready);
    end
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.out_valid !== 1'b0) seen++;
      tick();
    end
    n_cmp++; if (seen != 0) begin n_mis++; $display("FAIL mid_quiet got %0d valid cycles want 0", seen); end
    send_cmd(8'h40, 9'd2, 1'b0);
    collect(20, 1'b0);
    n_cmp++; if (timed_out || gd.size() != 2 || gd[0] !== 16'h140 || gd[1] !== 16'h141 || gl[0] !== 1'b0 || gc[0] != 2) begin
      n_mis++;
      $display("FAIL mid_next got %0d words first=%h want 2 words 0140,0141 from cyc 2", gd.size(), gd.size() > 0 ? gd[0] : 16'hxxxx);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h100 + 16'(i);
    bp_pat[0] = 1; bp_pat[1] = 0; bp_pat[2] = 0; bp_pat[3] = 1;
    bp_pat[4] = 0; bp_pat[5] = 1; bp_pat[6] = 1; bp_pat[7] = 0;
    rstn = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_start_addr = '0;
    bus.cmd_len = '0;
    bus.cmd_dir = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_ascending();
    test_desc_wrap();
    test_backpressure();
    test_len_zero();
    test_full_sweep();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side sequencer that sits directly downstream of the single-port traceback/wavefront BRAM. It accepts a (start address, length, direction) command, drives the BRAM address port with one read per cycle, absorbs the BRAM's one-cycle registered read latency, and presents the words as a valid/ready stream with a last flag. A two-entry skid buffer keeps full throughput under consumer backpressure without losing in-flight reads.

## Interface
- ADDR_WIDTH, 8, BRAM address width; must equal the BRAM instance's.
- DATA_WIDTH, 16, BRAM word width.

- clk  in  1  single clock; all state updates on rising edge.
- rstn  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_start_addr  in  ADDR_WIDTH  first address read.
- cmd_len  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH.
- cmd_dir  in  1  0 = ascending, 1 = descending (traceback order).
- bram_addr  out  ADDR_WIDTH  to BRAM addr.
- bram_writeEn  out  1  to BRAM writeEn; constant 0.
- bram_dataOut  in  DATA_WIDTH  from BRAM dataOut (registered, read-first).
- out_valid  out  1  stream word valid.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_WIDTH  stream word.
- out_last  out  1  high with final word of a command.
- busy  out  1  high from command accept until last word handshaked.

## Operation
- FSM: IDLE, READ, DRAIN.
  - IDLE: cmd_ready=1. On cmd_valid: load addr counter=cmd_start_addr, remaining=cmd_len, dir. If cmd_len=0 stay IDLE (no reads, no output, busy stays 0); else -> READ.
  - READ: issue read when remaining>0 and (buf_count + inflight - pop) < 2, where pop = out_valid && out_ready this cycle. On issue: remaining-1, addr +1 (dir=0) or -1 (dir=1), modulo 2^ADDR_WIDTH (max->0, 0->max). Remaining hits 0 on issue -> DRAIN.
  - DRAIN: no issues; -> IDLE on handshake of the word carrying out_last.
- bram_addr = addr counter register (combinational from it); BRAM keeps reading when not issuing; such data is ignored.
- inflight: 1-bit register = "issued last cycle"; when set, bram_dataOut is pushed into skid buffer that edge.
- Skid buffer: 2-entry FIFO, out_data/out_valid from head entry register; push and pop in same cycle allowed. Credit rule guarantees no overflow; overflow is a design error (assert in bench).
- out_last tagged on the pushed entry whose read was the final issue of the command.
- busy = (state != IDLE).
- No new command accepted until DRAIN completes; cmd_* ignored outside IDLE.

## Timing
- Reset (rstn=0 at an edge): state=IDLE, bram_addr=0, remaining=0, inflight=0, buffer empty; outputs: cmd_ready=1, out_valid=0, out_last=0, out_data=0, busy=0, bram_writeEn=0. Mid-command reset discards in-flight and buffered words; nothing emitted afterward.
- Accept edge E0. After E0: bram_addr=start, first issue. Edge E1: BRAM registers word. Edge E2: word enters buffer. out_valid=1 in cycle after E2 (2 cycles after accept cycle).
- With out_ready held 1: one word per cycle, N-word command spans accept cycle + N+2 cycles to last handshake; cmd_ready returns the cycle after last handshake.
- out_ready=0: at most 2 words buffered (1 buffered + 1 inflight, or 2 buffered); issue stalls; out_data/out_valid/out_last stable until handshake.
- Command with cmd_len=2^ADDR_WIDTH reads every address once, wrapping once.

## Test plan
- Preload mem[i]=i+0x100 (ADDR_WIDTH=8); cmd start=0x10, len=4, dir=0, out_ready=1 -> out_data 0x110,0x111,0x112,0x113 on consecutive cycles, out_valid first high 2 cycles after accept, out_last only on 0x113.
- Descending wrap: start=0x01, len=4, dir=1 -> 0x101,0x100,0x1FF,0x1FE, last on 0x1FE.
- Backpressure: len=8, out_ready toggled 1,0,0,1,0,1,... -> exactly 8 words in order 0x1xx ascending, no drop/duplicate, outputs stable while out_ready=0, bram_writeEn always 0.
- cmd_len=0 -> cmd_ready stays 1, busy never rises, no out_valid; following len=1 command emits single word with out_last=1.
- Full sweep len=256 start=0x80 dir=0 -> 256 words 0x180..0x1FF,0x100..0x17F, throughput 1/cycle.
- Reset mid-command after 3 of 10 words -> next cycle out_valid=0, busy=0, cmd_ready=1; no stale word appears on a subsequent len=2 command.
